decoder_using_fsm: RTL and testbench

Registered binary-to-one-hot decoder with an input handshake and a timed output pulse; it is the inverse of the 16-to-4 encoder block. A 4-bit code accepted on the input drives the matching bit of a 16-bit one-hot bus for a fixed number of cycles. The bus then goes to zero for a programmable gap before the next code is accepted. It sits on the output side of the encoder/decoder path and drives one-hot select lines (LED banks, mux selects) that need a guaranteed minimum pulse width and a guaranteed dead time.

---
 rtl/decoder_using_fsm_pkg.sv | 27 ++
 rtl/decoder_using_fsm.sv | 105 ++++++++++
 tb/tb_decoder_using_fsm.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/decoder_using_fsm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_pkg
//  Brief    : Shared types and helpers for the timed one-hot decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package decoder_pkg;

   localparam int DEF_IN_W = 4;
   // Widest code the onehot helper supports; callers size-cast the result.
   localparam int MAX_IN_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   function automatic logic [2**MAX_IN_W-1:0] onehot(input logic [MAX_IN_W-1:0] code);
      logic [2**MAX_IN_W-1:0] v;
      v    = '0;
      v[0] = 1'b1;
      return v << code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_using_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_using_fsm
//  Brief    : Registered binary-to-one-hot decoder with timed hold and gap.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_using_fsm
   import decoder_pkg::*;
#(
   parameter  int IN_W        = DEF_IN_W,
   parameter  int HOLD_CYCLES = 4,
   parameter  int GAP_CYCLES  = 1,
   localparam int OUT_W       = 2**IN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [IN_W-1:0]  binary_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] decoder_out,
   output logic             out_valid,
   output logic             busy
);

   localparam int c_max_hg = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W    = $clog2(c_max_hg + 1);
   localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

   generate
      if (HOLD_CYCLES < 1) begin : g_chk_hold
         $error("decoder_using_fsm: HOLD_CYCLES must be >= 1");
      end
      if (GAP_CYCLES < 0) begin : g_chk_gap
         $error("decoder_using_fsm: GAP_CYCLES must be >= 0");
      end
      if (IN_W > MAX_IN_W) begin : g_chk_in_w
         $error("decoder_using_fsm: IN_W exceeds MAX_IN_W");
      end
   endgenerate

   state_e             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [OUT_W-1:0]   r_out;
   logic [OUT_W-1:0]   w_code_onehot;

   assign w_code_onehot = OUT_W'(onehot(MAX_IN_W'(binary_in)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_out   <= '0;
      end else if (!enable) begin
         // Dropping enable abandons any hold/gap in progress, last cycle included.
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_out   <= w_code_onehot;
                  r_cnt   <= c_hold_load;
                  r_state <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_cnt_one;
               end else begin
                  r_out <= '0;
                  if (GAP_CYCLES > 0) begin
                     r_cnt   <= c_gap_load;
                     r_state <= ST_GAP;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - c_cnt_one;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
               r_out   <= '0;
            end
         endcase
      end
   end

   assign in_ready    = enable && (r_state == ST_IDLE);
   assign out_valid   = (r_state == ST_HOLD);
   assign busy        = (r_state != ST_IDLE);
   assign decoder_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_decoder_using_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_using_fsm
//  Brief    : Directed scoreboard bench for decoder_using_fsm.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_using_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        in_valid;
   logic [3:0]  binary_in;
   logic        in_ready;
   logic [15:0] decoder_out;
   logic        out_valid;
   logic        busy;

   logic        s_enable;
   logic        s_valid;
   logic [3:0]  s_code;
   logic        s_ready;
   logic [15:0] s_out;
   logic        s_out_valid;
   logic        s_busy;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [15:0] q[$];

   always #5 clk = ~clk;

   decoder_using_fsm #(.IN_W(4), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .binary_in(binary_in),
      .in_valid(in_valid), .in_ready(in_ready), .decoder_out(decoder_out),
      .out_valid(out_valid), .busy(busy)
   );

   decoder_using_fsm #(.IN_W(4), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_s (
      .clk(clk), .rst_n(rst_n), .enable(s_enable), .binary_in(s_code),
      .in_valid(s_valid), .in_ready(s_ready), .decoder_out(s_out),
      .out_valid(s_out_valid), .busy(s_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_onehot(input logic [3:0] code);
      logic [15:0] v;
      v = 16'h0001;
      return v << code;
   endfunction

   // Waits (bounded) for in_ready, presents the code for one accepting edge.
   task automatic send(input logic [3:0] code);
      binary_in = code;
      in_valid  = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) break;
         tick();
      end
      chk("wait_ready", {31'd0, in_ready}, 32'd1);
      tick();
      q.push_back(exp_onehot(code));
      in_valid = 1'b0;
   endtask

   initial begin
      int ready_cd;
      int hold_left;
      int accepts;
      logic [15:0] exp_out;

      rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; binary_in = 4'h0;
      s_enable = 1'b0; s_valid = 1'b0; s_code = 4'h0;
      #12;
      chk("rst_out",       {16'd0, decoder_out}, 32'h0);
      chk("rst_busy",      {31'd0, busy},        32'd0);
      chk("rst_out_valid", {31'd0, out_valid},   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      enable = 1'b1;
      #1;
      chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Reset mid-HOLD
      send(4'h3);
      chk("hold_3", {16'd0, decoder_out}, {16'd0, q[0]});
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out",  {16'd0, decoder_out}, 32'h0);
      chk("async_rst_busy", {31'd0, busy},        32'd0);
      q.delete();
      tick();
      rst_n = 1'b1;
      tick();

      // Basic decode: 4 hold cycles then a gap cycle
      for (int k = 0; k < 5; k++) begin
         logic [3:0] codes [5];
         codes = '{4'h1, 4'h2, 4'h3, 4'h8, 4'hF};
         send(codes[k]);
         for (int c = 0; c < 4; c++) begin
            chk("basic_hold", {16'd0, decoder_out}, {16'd0, q[0]});
            chk("basic_valid", {31'd0, out_valid}, 32'd1);
            tick();
         end
         chk("basic_gap_out",  {16'd0, decoder_out}, 32'h0);
         chk("basic_gap_busy", {31'd0, busy},        32'd1);
         void'(q.pop_front());
         tick();
      end
      chk("basic_literal_f", {16'd0, exp_onehot(4'hF)}, 32'h8000);

      // Disabled
      enable = 1'b0; in_valid = 1'b1; binary_in = 4'h0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("dis_ready", {31'd0, in_ready},    32'd0);
         chk("dis_out",   {16'd0, decoder_out}, 32'h0);
      end

      // Back-pressure: continuous valid with 4'h5
      binary_in = 4'h5;
      enable    = 1'b1;
      #1;
      ready_cd = 0; hold_left = 0; accepts = 0;
      for (int c = 0; c < 24; c++) begin
         exp_out = (hold_left > 0) ? q[0] : 16'h0;
         chk("bp_ready", {31'd0, in_ready},    {31'd0, (ready_cd == 0)});
         chk("bp_out",   {16'd0, decoder_out}, {16'd0, exp_out});
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) void'(q.pop_front());
         end
         if (ready_cd == 0) begin
            q.push_back(16'h0020);
            hold_left = 4;
            ready_cd  = 5;
            accepts++;
         end else begin
            ready_cd--;
         end
         tick();
      end
      chk("bp_accepts", accepts, 32'd4);
      in_valid = 1'b0;
      q.delete();
      for (int c = 0; c < 8; c++) tick();

      // Abort in the 2nd HOLD cycle
      send(4'hA);
      chk("abort_hold1", {16'd0, decoder_out}, {16'd0, q[0]});
      tick();
      chk("abort_hold2", {16'd0, decoder_out}, 32'h0400);
      enable = 1'b0;
      #1;
      chk("abort_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
      chk("abort_out",   {16'd0, decoder_out}, 32'h0);
      chk("abort_busy",  {31'd0, busy},        32'd0);
      chk("abort_valid", {31'd0, out_valid},   32'd0);
      enable = 1'b1;
      #1;
      chk("abort_reenable_ready", {31'd0, in_ready}, 32'd1);
      q.delete();

      // Parameter sweep instance: HOLD_CYCLES=1, GAP_CYCLES=0
      s_enable = 1'b1;
      s_valid  = 1'b1;
      for (int k = 0; k < 16; k++) begin
         s_code = 4'(k);
         #1;
         chk("sw_ready",     {31'd0, s_ready}, 32'd1);
         chk("sw_idle_out",  {16'd0, s_out},   32'h0);
         q.push_back(exp_onehot(4'(k)));
         tick();
         chk("sw_out",       {16'd0, s_out},   {16'd0, q.pop_front()});
         chk("sw_onebit",    $countones(s_out), 32'd1);
         chk("sw_busy_ready", {31'd0, s_ready}, 32'd0);
         tick();
      end
      s_valid = 1'b0;
      #1;
      chk("sw_final_out", {16'd0, s_out}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
